// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: datapath width, reset vector, fetch FSM
// encoding and the word-alignment helper.
package if_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for an instruction/PC pair that arrived while
// the IF/ID register was stalled and already occupied.
module if_skid_buf
    import if_fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            drain,
    input  logic            flush,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            skid_valid,
    output logic [XLEN-1:0] skid_instr,
    output logic [XLEN-1:0] skid_pc
);

    logic            valid_r;
    logic [XLEN-1:0] instr_r;
    logic [XLEN-1:0] pc_r;

    // Entry update: flush wins over load, load wins over drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            instr_r <= 32'd0;
            pc_r    <= 32'd0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            instr_r <= load_instr;
            pc_r    <= load_pc;
        end else if (drain) begin
            valid_r <= 1'b0;
        end
    end

    assign skid_valid = valid_r;
    assign skid_instr = instr_r;
    assign skid_pc    = pc_r;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding request/ack
// handshake to instruction memory and feeds the IF/ID pipeline register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] fetch_pc,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc4
);

    fetch_state_e    state_r;
    fetch_state_e    state_nxt_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_nxt_s;

    logic            ifid_valid_r;
    logic [XLEN-1:0] ifid_instr_r;
    logic [XLEN-1:0] ifid_pc_r;
    logic [XLEN-1:0] ifid_pc4_r;

    logic            skid_valid_s;
    logic [XLEN-1:0] skid_instr_s;
    logic [XLEN-1:0] skid_pc_s;

    logic            outstanding_s;
    logic            ack_live_s;
    logic            ifid_accept_s;
    logic            skid_load_s;
    logic            skid_drain_s;
    logic            req_s;

    // A redirect in the ack cycle turns that ack into a discard.
    assign outstanding_s = (state_r == WAIT) || (state_r == DROP);
    assign ack_live_s    = (state_r == WAIT) && imem_ack && !redirect_valid;
    assign ifid_accept_s = !stall || !ifid_valid_r;
    assign skid_load_s   = ack_live_s && !ifid_accept_s;
    assign skid_drain_s  = !stall && skid_valid_s;
    assign req_s         = !reset && !redirect_valid && (state_r == FETCH) && !skid_valid_s;

    assign imem_req   = req_s;
    assign imem_addr  = req_s ? word_align(pc_r) : {XLEN{1'b0}};
    assign fetch_pc   = pc_r;
    assign ifid_valid = ifid_valid_r;
    assign ifid_instr = ifid_instr_r;
    assign ifid_pc    = ifid_pc_r;
    assign ifid_pc4   = ifid_pc4_r;

    // Next fetch state and PC; redirect overrides the handshake progress.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        if (redirect_valid) begin
            pc_nxt_s = word_align(redirect_pc);
            if (outstanding_s && !imem_ack) begin
                state_nxt_s = DROP;
            end else begin
                state_nxt_s = FETCH;
            end
        end else begin
            case (state_r)
                FETCH: begin
                    if (!skid_valid_s) begin
                        state_nxt_s = WAIT;
                    end else begin
                        state_nxt_s = FETCH;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        state_nxt_s = FETCH;
                        pc_nxt_s    = pc_r + 32'd4;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state_nxt_s = FETCH;
                    end else begin
                        state_nxt_s = DROP;
                    end
                end
                default: state_nxt_s = FETCH;
            endcase
        end
    end

    // FSM and PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    // IF/ID register: skid entry drains before a fresh ack; a bubble fills even under stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= 32'd0;
            ifid_pc_r    <= 32'd0;
            ifid_pc4_r   <= 32'd0;
        end else if (redirect_valid) begin
            ifid_valid_r <= 1'b0;
        end else if (!stall) begin
            if (skid_valid_s) begin
                ifid_valid_r <= 1'b1;
                ifid_instr_r <= skid_instr_s;
                ifid_pc_r    <= skid_pc_s;
                ifid_pc4_r   <= skid_pc_s + 32'd4;
            end else if (ack_live_s) begin
                ifid_valid_r <= 1'b1;
                ifid_instr_r <= imem_rdata;
                ifid_pc_r    <= pc_r;
                ifid_pc4_r   <= pc_r + 32'd4;
            end else begin
                ifid_valid_r <= 1'b0;
            end
        end else if (ack_live_s && !ifid_valid_r) begin
            ifid_valid_r <= 1'b1;
            ifid_instr_r <= imem_rdata;
            ifid_pc_r    <= pc_r;
            ifid_pc4_r   <= pc_r + 32'd4;
        end
    end

    if_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load_s),
        .drain      (skid_drain_s),
        .flush      (redirect_valid),
        .load_instr (imem_rdata),
        .load_pc    (pc_r),
        .skid_valid (skid_valid_s),
        .skid_instr (skid_instr_s),
        .skid_pc    (skid_pc_s)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by random
// stall/redirect/latency traffic against a transaction-level reference model.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] fetch_pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;

    int checks_r = 0;
    int errors_r = 0;

    // memory responder
    bit          mem_busy;
    int          mem_cnt;
    int          mem_lat;
    logic [31:0] mem_addr;

    // reference model: PC, outstanding/discard flags, IF/ID slot, skid queue
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_drop;
    bit          m_ifid_valid;
    logic [31:0] m_ifid_pc;
    logic [31:0] m_skid[$];

    int          cyc;
    logic [31:0] req_log[$];
    int          req_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .fetch_pc       (fetch_pc),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc4       (ifid_pc4)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc         = RESET_PC;
        m_out        = 1'b0;
        m_drop       = 1'b0;
        m_ifid_valid = 1'b0;
        m_ifid_pc    = 32'd0;
        m_skid.delete();
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model.
    task automatic run_cycle(input bit rst, input bit redir, input logic [31:0] tgt, input bit stl);
        bit          ack;
        bit          exp_req;
        bit          out_before;
        bit          ack_live;
        logic [31:0] ack_pc;
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = tgt;
        stall          = stl;
        ack            = 1'b0;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                ack      = 1'b1;
                mem_busy = 1'b0;
            end
        end
        imem_ack   = ack;
        imem_rdata = ack ? instr_of(mem_addr) : $urandom();
        @(negedge clk);
        check_val("fetch_pc", fetch_pc, m_pc);
        check_val("ifid_valid", 32'(ifid_valid), 32'(m_ifid_valid));
        if (m_ifid_valid) begin
            check_val("ifid_pc", ifid_pc, m_ifid_pc);
            check_val("ifid_instr", ifid_instr, instr_of(m_ifid_pc));
            check_val("ifid_pc4", ifid_pc4, m_ifid_pc + 32'd4);
        end
        out_before = m_out;
        exp_req    = !rst && !redir && !m_out && (m_skid.size() == 0);
        check_val("imem_req", 32'(imem_req), 32'(exp_req));
        if (imem_req) begin
            check_val("imem_addr", imem_addr, m_pc);
            req_log.push_back(imem_addr);
            req_cyc.push_back(cyc);
            mem_busy = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = imem_addr;
        end
        ack_pc   = m_pc;
        ack_live = ack && out_before && !m_drop && !rst && !redir;
        if (rst) begin
            model_reset();
        end else if (redir) begin
            m_out        = out_before && !ack;
            m_drop       = m_out;
            m_pc         = {tgt[31:2], 2'b00};
            m_ifid_valid = 1'b0;
            m_skid.delete();
        end else begin
            if (out_before && ack) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
                if (ack_live) m_pc = m_pc + 32'd4;
            end
            if (!stl) begin
                if (m_skid.size() != 0) begin
                    m_ifid_valid = 1'b1;
                    m_ifid_pc    = m_skid.pop_front();
                end else if (ack_live) begin
                    m_ifid_valid = 1'b1;
                    m_ifid_pc    = ack_pc;
                end else begin
                    m_ifid_valid = 1'b0;
                end
            end else if (ack_live) begin
                if (!m_ifid_valid) begin
                    m_ifid_valid = 1'b1;
                    m_ifid_pc    = ack_pc;
                end else begin
                    m_skid.push_back(ack_pc);
                end
            end
            if (exp_req) m_out = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit stl);
        for (int k = 0; k < n; k++) run_cycle(1'b0, 1'b0, 32'd0, stl);
    endtask

    task automatic check_log(input string tag, input int idx, input logic [31:0] exp);
        if (req_log.size() > idx) begin
            check_val(tag, req_log[idx], exp);
        end else begin
            check_val({tag, "_missing"}, 32'(req_log.size()), 32'(idx + 1));
        end
    endtask

    bit          r_rst;
    bit          r_redir;
    bit          r_stall;
    logic [31:0] r_tgt;

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        stall          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'd0;
        mem_busy       = 1'b0;
        mem_cnt        = 0;
        mem_lat        = 1;
        mem_addr       = 32'd0;
        cyc            = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_imem_req", 32'(imem_req), 32'd0);
        check_val("rst_imem_addr", imem_addr, 32'd0);
        check_val("rst_ifid_valid", 32'(ifid_valid), 32'd0);
        check_val("rst_ifid_instr", ifid_instr, 32'd0);
        check_val("rst_ifid_pc", ifid_pc, 32'd0);
        check_val("rst_ifid_pc4", ifid_pc4, 32'd0);
        check_val("rst_fetch_pc", fetch_pc, 32'h0000_3000);

        // straight-line fetch with 1-cycle memory
        req_log.delete();
        req_cyc.delete();
        idle(8, 1'b0);
        check_log("seq_addr0", 0, 32'h0000_3000);
        check_log("seq_addr1", 1, 32'h0000_3004);
        check_log("seq_addr2", 2, 32'h0000_3008);
        if (req_cyc.size() > 1) check_val("seq_spacing", 32'(req_cyc[1] - req_cyc[0]), 32'd2);
        if (req_cyc.size() > 0) check_val("first_req_cycle", 32'(req_cyc[0]), 32'd0);

        // stall lands on the ack for 0x3004
        run_cycle(1'b1, 1'b0, 32'd0, 1'b0);
        idle(3, 1'b0);
        idle(2, 1'b1);
        idle(6, 1'b0);

        // redirect while waiting, ack three cycles late
        run_cycle(1'b1, 1'b0, 32'd0, 1'b0);
        mem_lat = 4;
        idle(1, 1'b0);
        mem_lat = 1;
        req_log.delete();
        run_cycle(1'b0, 1'b1, 32'h0000_3100, 1'b0);
        idle(7, 1'b0);
        check_log("late_redirect_addr", 0, 32'h0000_3100);

        // redirect, ack and stall together
        run_cycle(1'b1, 1'b0, 32'd0, 1'b0);
        idle(1, 1'b0);
        req_log.delete();
        run_cycle(1'b0, 1'b1, 32'h0000_4440, 1'b1);
        idle(6, 1'b0);
        check_log("flush_all_addr", 0, 32'h0000_4440);

        // PC wrap at the top of the address space
        req_log.delete();
        run_cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        idle(8, 1'b0);
        check_log("wrap_addr0", 0, 32'hFFFF_FFFC);
        check_log("wrap_addr1", 1, 32'h0000_0000);

        // misaligned target
        req_log.delete();
        run_cycle(1'b0, 1'b1, 32'h0000_3102, 1'b0);
        idle(6, 1'b0);
        check_log("align_addr", 0, 32'h0000_3100);

        // reset during WAIT with the old ack landing afterwards
        run_cycle(1'b1, 1'b0, 32'd0, 1'b0);
        mem_lat = 2;
        idle(1, 1'b0);
        run_cycle(1'b1, 1'b0, 32'd0, 1'b0);
        req_log.delete();
        idle(8, 1'b0);
        check_log("post_reset_addr", 0, 32'h0000_3000);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r_rst   = ($urandom_range(99) == 0);
            r_redir = ($urandom_range(19) == 0);
            r_stall = ($urandom_range(9) < 3);
            if ($urandom_range(3) == 0) begin
                r_tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            end else begin
                r_tgt = $urandom();
            end
            mem_lat = $urandom_range(4, 1);
            run_cycle(r_rst, r_redir, r_tgt, r_stall);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the pipelined MIPS CPU: owns the architectural PC, issues word fetches to instruction memory over a single-outstanding request/acknowledge handshake, and delivers fetched instructions into the IF/ID pipeline register. It consumes the next-address side of the design: the taken-branch/jump redirect from next-PC logic, and the bubble/stall from the hazard unit. It also returns the current PC to next-PC logic.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded by reset.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- redirect_valid  in  1  branch taken or jump (j/jal/jalr) resolved this cycle.
- redirect_pc  in  32  target address, valid with redirect_valid.
- stall  in  1  hazard bubble; the IF/ID register holds its value.
- imem_req  out  1  one-cycle request pulse.
- imem_addr  out  32  word address, valid with imem_req; low 2 bits always 0.
- imem_ack  in  1  one-cycle response pulse, at least 1 cycle after imem_req.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- fetch_pc  out  32  current PC register, fed to next-PC logic.
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc  out  32  address of ifid_instr.
- ifid_pc4  out  32  ifid_pc + 4, modulo 2^32.

## Operation
- FSM states: FETCH, WAIT, DROP.
- Priority: reset > redirect_valid > stall > normal flow.
- One-entry skid buffer (skid_valid, skid_instr, skid_pc) absorbs a response that arrives while stall=1 and ifid_valid=1.
- FETCH: if skid empty, assert imem_req with imem_addr = {pc[31:2],2'b00} and go to WAIT. Otherwise stay and do not request.
- WAIT, imem_ack=1:
  - If IF/ID can accept (stall=0, or ifid_valid=0), load IF/ID directly. Otherwise write the skid buffer.
  - Then pc <= pc+4 and go to FETCH.
- IF/ID update when stall=0: skid entry first (clears skid). Otherwise this cycle's accepted ack. Otherwise ifid_valid <= 0.
- stall=1: ifid_* held.
- Redirect in any state:
  - Clear ifid_valid and skid_valid; pc <= {redirect_pc[31:2],2'b00}.
  - State <= DROP if a request is outstanding and no ack arrives this cycle. Otherwise state <= FETCH.
  - No imem_req issues that cycle.
- DROP: wait for imem_ack and discard imem_rdata, then go to FETCH. A further redirect in DROP updates pc and stays in DROP.
- pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=0, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc4=0, skid_valid=0.
- Reset mid-request: the outstanding ack is ignored. The first cycle after reset is FETCH.
- First imem_req is in the first cycle after reset deasserts, with addr 32'h0000_3000.
- Latency: ack in cycle N -> ifid_valid=1 in cycle N+1 (when accepted). Next imem_req in cycle N+1.
- Throughput with 1-cycle memory: one instruction per 2 cycles.
- Redirect in cycle N -> ifid_valid=0 in N+1.
  - From FETCH or WAIT with ack in N: request for the target in N+1.
  - From WAIT without ack: request one cycle after the ack.
- Ack and redirect in the same cycle: the ack is discarded.
- Stall and redirect in the same cycle: the flush wins.
- At most one request outstanding at any time.
- Never both skid_valid=1 and a request outstanding with ifid_valid=1 and stall=1.

## Structure
- Shared CPU package holds RESET_PC (32'h0000_3000), the 32-bit address/data width constant, and the fetch state enum {FETCH, WAIT, DROP}.
- Sub-module if_skid_buf is the one-entry instr/pc holding register with load, drain and flush.

## Test plan
- Reset, memory acks 1 cycle after each request, stall=0:
  - imem_addr sequence 0x3000, 0x3004, 0x3008 on alternate cycles.
  - ifid_pc4 = 0x3004 when ifid_pc = 0x3000.
- stall=1 when the ack for 0x3004 arrives:
  - Instruction captured in skid; no request while skid is full.
  - After stall drops, IF/ID shows 0x3004, then the fetch of 0x3008 issues.
- redirect_valid with redirect_pc=0x3100 while WAIT, ack 3 cycles late:
  - Late data discarded; ifid_valid=0.
  - Next imem_addr = 0x3100.
- Redirect, ack and stall in the same cycle:
  - IF/ID flushed, ack discarded.
  - Next request addr = redirect target.
- redirect_pc=0xFFFF_FFFC:
  - Fetch 0xFFFF_FFFC, then 0x0000_0000.
  - ifid_pc4 = 0x0000_0000.
- redirect_pc=0x3102 is fetched as 0x3100. Reset asserted mid-WAIT: next request is 0x3000 and the stale ack is ignored.
